// File: rtl/draw_char_board_scaled_if.sv
// VGA timing/colour bundle and game-settings bundle shared by the redraw chain.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

interface game_set_if;
  logic [10:0] board_xpos;
  logic [10:0] board_ypos;
  logic [10:0] board_size;
  logic [10:0] button_size;
  logic [4:0]  button_num;

  modport in (input board_xpos, board_ypos, board_size, button_size, button_num);
endinterface

// File: rtl/draw_char_board_scaled.sv
// Board digit overlay: scaled, centred glyphs per field over a fixed 3-clock VGA pipeline.
// Optional macro CHAR_PALETTE_EN selects a per-digit colour palette instead of CHAR_RGB.
module draw_char_board_scaled #(
  parameter int          GLYPH_W    = 8,
  parameter int          GLYPH_H    = 16,
  parameter int          SCALE      = 2,
  parameter int          MAX_FIELDS = 16,
  parameter logic [11:0] CHAR_RGB   = 12'h20a
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [GLYPH_W-1:0]            char_pixels,
  input  logic [3:0]                    char_code,
  output logic [$clog2(MAX_FIELDS)-1:0] char_x,
  output logic [$clog2(MAX_FIELDS)-1:0] char_y,
  output logic [$clog2(GLYPH_H)-1:0]    char_line,
  output logic                          char_en,
  vga_if.in                             in,
  vga_if.out                            out,
  game_set_if.in                        gin
);

  localparam int              AW       = $clog2(MAX_FIELDS);
  localparam int              LW       = $clog2(GLYPH_H);
  localparam int              FW       = $clog2(GLYPH_W);
  localparam logic [10:0]     BOX_W    = 11'(GLYPH_W * SCALE);
  localparam logic [10:0]     BOX_H    = 11'(GLYPH_H * SCALE);
  localparam logic [1:0]      SUB_MAX  = 2'(SCALE - 1);
  localparam logic [FW-1:0]   FCOL_TOP = FW'(GLYPH_W - 1);

  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_t;

  vga_t vin_c, s1_q, s2_q, o_q;

  // Board geometry is sampled at each line start so mid-line changes wait for the next line.
  logic        line_start;
  logic [10:0] xpos_l, bs_l, xpos_c, bs_c, num_c, gx0_c, gy0_c;
  logic [4:0]  num_l;

  logic [10:0] col_q, xoff_q, col_c, xoff_c;
  logic [10:0] row_q, yoff_q, row_c, yoff_c;
  logic        inx_q, iny_q, inx_c, iny_c;
  logic [FW-1:0] fcol_q, fcol_c, fcol_s1;
  logic [LW-1:0] fline_q, fline_c;
  logic [1:0]  xsub_q, xsub_c, ysub_q, ysub_c;
  logic        gx_in, gy_in, en_c;

  logic        draw_q;
  logic [11:0] colour_c, colour_q;

  assign vin_c      = {in.vcount, in.vsync, in.vblnk, in.hcount, in.hsync, in.hblnk, in.rgb};
  assign line_start = (in.hcount == 11'd0);
  assign xpos_c     = line_start ? gin.board_xpos  : xpos_l;
  assign bs_c       = line_start ? gin.button_size : bs_l;
  assign num_c      = line_start ? 11'(gin.button_num) : 11'(num_l);
  assign gx0_c      = (bs_c >= BOX_W) ? ((bs_c - BOX_W) >> 1) : '0;
  assign gy0_c      = (bs_c >= BOX_H) ? ((bs_c - BOX_H) >> 1) : '0;

  // Column/offset counters plus font-column sub-counter (replaces divide by SCALE).
  always_comb begin
    col_c  = col_q;
    xoff_c = xoff_q;
    inx_c  = inx_q;
    fcol_c = fcol_q;
    xsub_c = xsub_q;
    if (in.hcount == xpos_c) begin
      col_c  = '0;
      xoff_c = '0;
      inx_c  = (num_c != 11'd0);
    end else if (line_start) begin
      inx_c = 1'b0;
    end else if (inx_q) begin
      if (xoff_q == bs_c - 11'd1) begin
        xoff_c = '0;
        col_c  = col_q + 11'd1;
        if (col_q + 11'd1 == num_c) inx_c = 1'b0;
      end else begin
        xoff_c = xoff_q + 11'd1;
      end
    end
    if (xoff_c == gx0_c) begin
      fcol_c = '0;
      xsub_c = '0;
    end else if (xsub_q == SUB_MAX) begin
      fcol_c = fcol_q + 1'b1;
      xsub_c = '0;
    end else begin
      xsub_c = xsub_q + 2'd1;
    end
  end

  // Row/offset counters and font-line sub-counter only move at line start.
  always_comb begin
    row_c   = row_q;
    yoff_c  = yoff_q;
    iny_c   = iny_q;
    fline_c = fline_q;
    ysub_c  = ysub_q;
    if (line_start) begin
      if (in.vcount == gin.board_ypos) begin
        row_c  = '0;
        yoff_c = '0;
        iny_c  = (num_c != 11'd0);
      end else if (in.vcount == 11'd0) begin
        iny_c = 1'b0;
      end else if (iny_q) begin
        if (yoff_q == bs_c - 11'd1) begin
          yoff_c = '0;
          row_c  = row_q + 11'd1;
          if (row_q + 11'd1 == num_c) iny_c = 1'b0;
        end else begin
          yoff_c = yoff_q + 11'd1;
        end
      end
      if (yoff_c == gy0_c) begin
        fline_c = '0;
        ysub_c  = '0;
      end else if (ysub_q == SUB_MAX) begin
        fline_c = fline_q + 1'b1;
        ysub_c  = '0;
      end else begin
        ysub_c = ysub_q + 2'd1;
      end
    end
  end

  assign gx_in = (xoff_c >= gx0_c) && (xoff_c < gx0_c + BOX_W);
  assign gy_in = (yoff_c >= gy0_c) && (yoff_c < gy0_c + BOX_H);
  assign en_c  = inx_c && iny_c && gx_in && gy_in;

`ifdef CHAR_PALETTE_EN
  always_comb begin
    case (char_code)
      4'd1:    colour_c = 12'h00F;
      4'd2:    colour_c = 12'h080;
      4'd3:    colour_c = 12'hF00;
      4'd4:    colour_c = 12'h008;
      4'd5:    colour_c = 12'h800;
      4'd6:    colour_c = 12'h088;
      4'd7:    colour_c = 12'h000;
      4'd8:    colour_c = 12'h888;
      default: colour_c = CHAR_RGB;
    endcase
  end
`else
  assign colour_c = CHAR_RGB;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xpos_l    <= '0;
      bs_l      <= '0;
      num_l     <= '0;
      col_q     <= '0;
      xoff_q    <= '0;
      inx_q     <= 1'b0;
      row_q     <= '0;
      yoff_q    <= '0;
      iny_q     <= 1'b0;
      fcol_q    <= '0;
      xsub_q    <= '0;
      fline_q   <= '0;
      ysub_q    <= '0;
      char_en   <= 1'b0;
      char_x    <= '0;
      char_y    <= '0;
      char_line <= '0;
      fcol_s1   <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      draw_q    <= 1'b0;
      colour_q  <= '0;
      o_q       <= '0;
    end else begin
      xpos_l  <= xpos_c;
      bs_l    <= bs_c;
      num_l   <= num_c[4:0];
      col_q   <= col_c;
      xoff_q  <= xoff_c;
      inx_q   <= inx_c;
      row_q   <= row_c;
      yoff_q  <= yoff_c;
      iny_q   <= iny_c;
      fcol_q  <= fcol_c;
      xsub_q  <= xsub_c;
      fline_q <= fline_c;
      ysub_q  <= ysub_c;
      // Stage 1: memory addresses.
      char_en <= en_c;
      if (en_c) begin
        char_x    <= col_c[AW-1:0];
        char_y    <= row_c[AW-1:0];
        char_line <= fline_c;
      end
      fcol_s1 <= fcol_c;
      s1_q    <= vin_c;
      // Stage 2: font row and board code arrive.
      draw_q   <= char_en && (char_code != 4'd0) && char_pixels[FCOL_TOP - fcol_s1];
      colour_q <= colour_c;
      s2_q     <= s1_q;
      // Stage 3: output register.
      o_q <= s2_q;
      if (draw_q && !s2_q.hblnk && !s2_q.vblnk) o_q.rgb <= colour_q;
    end
  end

  assign out.vcount = o_q.vcount;
  assign out.vsync  = o_q.vsync;
  assign out.vblnk  = o_q.vblnk;
  assign out.hcount = o_q.hcount;
  assign out.hsync  = o_q.hsync;
  assign out.hblnk  = o_q.hblnk;
  assign out.rgb    = o_q.rgb;

endmodule
